fetch_unit: RTL

Instruction-fetch responder for the SISC computer: it carries out the PC and IR commands issued by the control FSM (`pc_rst`, `pc_write`, `pc_sel`, `br_sel`, `ir_load`). It owns the program counter, the instruction register and the branch-address adder. It runs a request/acknowledge handshake with a variable-latency instruction memory and reports fetch completion and timeouts back to control.

---
 rtl/sisc_pkg.sv | 36 +++
 rtl/fetch_unit_pc_reg.sv | 40 ++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// sisc_pkg: constants shared across the SISC processor.
// It holds the opcodes, the instruction-register field positions and the fetch-state encoding.
package sisc_pkg;

    // Opcode field values (ir[31:28])
    typedef enum logic [3:0] {
        NOOP   = 4'd0,
        LOD    = 4'd1,
        STR    = 4'd2,
        SWP    = 4'd3,
        BRA    = 4'd4,
        BRR    = 4'd5,
        BNE    = 4'd6,
        BNR    = 4'd7,
        ALU_OP = 4'd8,
        HLT    = 4'd15
    } opcode_t;

    // Instruction-register field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int MM_MSB     = 27;
    localparam int MM_LSB     = 24;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // The wait counter is wide enough for MAX_WAIT up to 255
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: the program counter, together with the next-PC and branch-target muxes.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              pc_rst,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic              br_sel,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] br_addr
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_in;

    // Branch target (absolute or PC-relative) and next-PC candidate
    always_comb begin
        br_addr = br_sel ? imm : pc_q + imm;
        pc_in   = pc_sel ? br_addr : pc_q + ADDR_W'(1);
    end

    // PC register: a clear takes priority over a load
    always_ff @(posedge clk or negedge rst_f) begin
        // NOTE: non-blocking assignments in clocked blocks avoid read/write ordering races between flops.
        if (!rst_f) begin
            pc_q <= '0;
        end else if (pc_rst) begin
            pc_q <= '0;
        end else if (pc_write) begin
            pc_q <= pc_in;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, the IR and the instruction-memory request/acknowledge handshake.
// A rising edge on ir_load starts one fetch. The fetch ends on an ack, or on a timeout
// after MAX_WAIT request cycles, and ir_valid then pulses for one cycle.
module fetch_unit
    import sisc_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    input  logic               im_ack,
    input  logic [INSTR_W-1:0] im_data,
    output logic               im_req,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  br_addr,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic               fetch_err
);

    // Timeout fires at the end of the MAX_WAIT-th request cycle with no ack
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    fetch_state_t      state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ir_load_q;
    logic              start, got_ack, timed_out;
    logic [ADDR_W-1:0] imm;

    assign imm = ADDR_W'(ir[IMM_MSB:IMM_LSB]);

    pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clk      (clk),
        .rst_f    (rst_f),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .imm      (imm),
        .pc_out   (pc_out),
        .br_addr  (br_addr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= FS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and fetch events; pc_rst overrides everything
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        next_state = state;
        start      = 1'b0;
        got_ack    = 1'b0;
        timed_out  = 1'b0;
        unique case (state)
            FS_IDLE: begin
                if (ir_load && !ir_load_q) begin
                    next_state = FS_REQ;
                    start      = 1'b1;
                end
            end
            FS_REQ: begin
                if (im_ack) begin
                    next_state = FS_DONE;
                    got_ack    = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = FS_DONE;
                    timed_out  = 1'b1;
                end
            end
            FS_DONE: next_state = FS_IDLE;
            default: next_state = FS_IDLE;
        endcase
        if (pc_rst) begin
            next_state = FS_IDLE;
            start      = 1'b0;
            got_ack    = 1'b0;
            timed_out  = 1'b0;
        end
    end

    // Request, address latch, wait counter, IR and sticky error
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            ir_load_q <= 1'b0;
            im_req    <= 1'b0;
            im_addr   <= '0;
            wait_cnt  <= '0;
            ir        <= '0;
            fetch_err <= 1'b0;
        end else begin
            ir_load_q <= ir_load;
            if (pc_rst) begin
                im_req   <= 1'b0;
                wait_cnt <= '0;
                ir       <= '0;
            end else begin
                if (start) begin
                    im_addr  <= pc_out;
                    im_req   <= 1'b1;
                    wait_cnt <= '0;
                end else if (state == FS_REQ) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (got_ack) begin
                    ir     <= im_data;
                    im_req <= 1'b0;
                end
                if (timed_out) begin
                    ir        <= '0;
                    im_req    <= 1'b0;
                    fetch_err <= 1'b1;
                end
            end
        end
    end

    assign ir_valid = (state == FS_DONE);

endmodule
